axis_frame_packer: RTL and testbench

//  Downstream of the AXI-to-stream capture stage. Consumes the per-channel beat stream (AR/AW/R/W/B,

---
 rtl/axis_pkt_pkg.sv | 40 ++++
 rtl/axis_pkt_fifo.sv | 50 +++++
 rtl/axis_frame_packer.sv | 170 +++++++++++++++++
 tb/tb_axis_frame_packer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_pkg.sv
// Shared types for the AXI channel frame packer: header layout, channel ids, close reasons, FSM states.
package axis_pkt_pkg;

  localparam logic [15:0] PKT_MAGIC = 16'hE7B5;
  localparam logic [7:0]  FLAG_CKS  = 8'h80;

  typedef enum logic [2:0] {
    CH_AR = 3'd0,
    CH_AW = 3'd1,
    CH_R  = 3'd2,
    CH_W  = 3'd3,
    CH_B  = 3'd4
  } chan_e;

  // Encoded directly as the header flag bit of the winning reason
  typedef enum logic [7:0] {
    RSN_NONE  = 8'h00,
    RSN_TMO   = 8'h01,
    RSN_CHG   = 8'h02,
    RSN_TLAST = 8'h04,
    RSN_MAX   = 8'h08
  } close_reason_e;

  typedef struct packed {
    logic [15:0] magic;
    logic [15:0] seq;
    logic [15:0] count;
    logic [4:0]  rsvd;
    chan_e       ch;
    logic [7:0]  flags;
  } pkt_hdr_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    TRAILER = 2'd3
  } state_e;

endpackage

// File: rtl/axis_pkt_fifo.sv
// First-word-fall-through payload FIFO; head is read straight from the register array.
module axis_pkt_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axis_frame_packer.sv
// Packs runs of same-channel capture beats into header+payload frames for the Ethernet TX path.
// Build option PKT_CHECKSUM_EN appends an XOR trailer beat and sets header flag bit 7.
module axis_frame_packer
  import axis_pkt_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int MAX_BEATS   = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [2:0]        s_axis_tid,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [31:0]       frames_sent,
  output logic [15:0]       bad_tid_cnt
);
  localparam int            TW       = $clog2(TIMEOUT_CYC);
  localparam logic [15:0]   MAX_CNT  = 16'(MAX_BEATS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e          state;
  logic [15:0]     count;
  logic [15:0]     idx;
  logic [15:0]     seq;
  chan_e           cur_ch;
  logic [7:0]      flags;
  logic [TW-1:0]   timer;
  close_reason_e   rsn;
  pkt_hdr_t        hdr;
  logic            fifo_full;
  logic            fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic            tid_bad;
  logic            acc_good;
  logic            acc_bad;
  logic            out_hs;
  logic            last_pay;
  logic            frame_done;

  assign tid_bad  = (s_axis_tid > 3'd4);
  assign s_axis_tready = !areset && (state == COLLECT) && !fifo_full &&
                         (count == '0 || tid_bad || s_axis_tid == cur_ch);
  assign acc_good = s_axis_tvalid && s_axis_tready && !tid_bad;
  assign acc_bad  = s_axis_tvalid && s_axis_tready && tid_bad;
  assign out_hs   = m_axis_tvalid && m_axis_tready;
  assign last_pay = (idx == count - 16'd1);

`ifdef PKT_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
  assign frame_done = out_hs && (state == TRAILER);
  assign hdr = '{magic: PKT_MAGIC, seq: seq, count: count, rsvd: '0, ch: cur_ch,
                 flags: flags | FLAG_CKS};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)          csum <= '0;
    else if (frame_done) csum <= '0;
    else if (acc_good)   csum <= csum ^ s_axis_tdata;
  end
`else
  assign frame_done = out_hs && (state == PAYLOAD) && last_pay;
  assign hdr = '{magic: PKT_MAGIC, seq: seq, count: count, rsvd: '0, ch: cur_ch,
                 flags: flags};
`endif

  // A held channel-change beat outranks the timeout; the timeout only fires on a truly idle cycle
  always_comb begin
    rsn = RSN_NONE;
    if (state == COLLECT) begin
      if (acc_good && count + 16'd1 == MAX_CNT)                         rsn = RSN_MAX;
      else if (acc_good && s_axis_tlast)                                 rsn = RSN_TLAST;
      else if (count != '0 && s_axis_tvalid && !tid_bad && s_axis_tid != cur_ch) rsn = RSN_CHG;
      else if (count != '0 && !acc_good && timer == TMO_LAST)            rsn = RSN_TMO;
    end
  end

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    case (state)
      HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr;
      end
      PAYLOAD: begin
        m_axis_tvalid = !fifo_empty;
        m_axis_tdata  = fifo_head;
`ifndef PKT_CHECKSUM_EN
        m_axis_tlast  = last_pay;
`endif
      end
`ifdef PKT_CHECKSUM_EN
      TRAILER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = csum;
        m_axis_tlast  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= COLLECT;
      count       <= '0;
      idx         <= '0;
      seq         <= '0;
      cur_ch      <= CH_AR;
      flags       <= '0;
      timer       <= '0;
      frames_sent <= '0;
      bad_tid_cnt <= '0;
    end else begin
      if (acc_bad && bad_tid_cnt != 16'hFFFF) bad_tid_cnt <= bad_tid_cnt + 16'd1;
      case (state)
        COLLECT: begin
          if (acc_good) begin
            count <= count + 16'd1;
            if (count == '0) cur_ch <= chan_e'(s_axis_tid);
          end
          if (acc_good || count == '0) timer <= '0;
          else                         timer <= timer + TW'(1);
          if (rsn != RSN_NONE) begin
            flags <= rsn;
            state <= HEADER;
            timer <= '0;
          end
        end
        HEADER: if (out_hs) begin
          state <= PAYLOAD;
          idx   <= '0;
        end
        PAYLOAD: if (out_hs) begin
          idx <= idx + 16'd1;
`ifdef PKT_CHECKSUM_EN
          if (last_pay) state <= TRAILER;
`endif
        end
        default: ;
      endcase
      if (frame_done) begin
        state       <= COLLECT;
        count       <= '0;
        flags       <= '0;
        seq         <= seq + 16'd1;
        frames_sent <= frames_sent + 32'd1;
      end
    end
  end

  axis_pkt_fifo #(.DEPTH(MAX_BEATS), .W(DATA_W)) u_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push      (acc_good),
    .push_data (s_axis_tdata),
    .pop       (out_hs && state == PAYLOAD),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_axis_frame_packer.sv
// Frame packer bench: directed and random beat sequences scored against a frame-level model.
module tb_axis_frame_packer;

  localparam int MAXB = 32;
  localparam int TMO  = 1024;
`ifdef PKT_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  typedef struct {
    logic [2:0]  tid;
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [63:0] s_axis_tdata = '0;
  logic [2:0]  s_axis_tid = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [31:0] frames_sent;
  logic [15:0] bad_tid_cnt;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;

  beat_t       stim[$];
  logic [64:0] exp_q[$];
  logic [64:0] out_q[$];
  logic [15:0] exp_seq = '0;
  logic [31:0] exp_frames = '0;
  logic [15:0] exp_bad = '0;
  logic        prev_stall = 1'b0;
  logic [64:0] prev_beat = '0;

  axis_frame_packer #(.DATA_W(64), .MAX_BEATS(MAXB), .TIMEOUT_CYC(TMO)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tid(s_axis_tid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .frames_sent(frames_sent), .bad_tid_cnt(bad_tid_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output-side ready pattern, changed just after the rising edge
  initial begin
    int ph = 0;
    forever begin
      @(posedge aclk); #1;
      ph = (ph + 1) % 3;
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (ph == 0);
        default: m_axis_tready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Output monitor: collects handshaken beats and checks stall stability
  initial begin
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 65'(m_axis_tvalid), 65'd1);
          check("stall_beat", {m_axis_tlast, m_axis_tdata}, prev_beat);
        end
        if (m_axis_tvalid) check("in_blocked", 65'(s_axis_tready), 65'd0);
        if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = {m_axis_tlast, m_axis_tdata};
      end
    end
  end

  function automatic void emit(ref logic [63:0] pay[$], input int ch, input logic [7:0] fl);
    logic [63:0] x = '0;
    int n = pay.size();
    exp_q.push_back({1'b0, 16'hE7B5, exp_seq, 16'(n), 5'b0, 3'(ch), fl | (CKS ? 8'h80 : 8'h00)});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(!CKS && i == n - 1), pay[i]});
      x = x ^ pay[i];
    end
    if (CKS) exp_q.push_back({1'b1, x});
    exp_seq    = exp_seq + 16'd1;
    exp_frames = exp_frames + 32'd1;
    pay.delete();
  endfunction

  // Frame-level reference: beats streamed without gaps, leftover partial frame ends by timeout
  function automatic void model();
    logic [63:0] pay[$];
    int ch = 0;
    foreach (stim[i]) begin
      if (stim[i].tid >= 3'd5) begin
        if (exp_bad != 16'hFFFF) exp_bad = exp_bad + 16'd1;
        continue;
      end
      if (pay.size() > 0 && int'(stim[i].tid) != ch) emit(pay, ch, 8'h02);
      if (pay.size() == 0) ch = int'(stim[i].tid);
      pay.push_back(stim[i].data);
      if (pay.size() == MAXB)  emit(pay, ch, 8'h08);
      else if (stim[i].last)   emit(pay, ch, 8'h04);
    end
    if (pay.size() > 0) emit(pay, ch, 8'h01);
  endfunction

  task automatic drive_beats();
    int n;
    @(posedge aclk); #1;
    foreach (stim[i]) begin
      s_axis_tvalid = 1'b1;
      s_axis_tid    = stim[i].tid;
      s_axis_tdata  = stim[i].data;
      s_axis_tlast  = stim[i].last;
      n = 0;
      @(negedge aclk);
      while (!s_axis_tready && n < 4000) begin
        @(negedge aclk);
        n++;
      end
      if (n >= 4000) begin
        check("in_accept_timeout", 65'(s_axis_tready), 65'd1);
        break;
      end
      @(posedge aclk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic run_seq(input string tag, input bit measure_tmo);
    int n;
    exp_q.delete();
    out_q.delete();
    model();
    drive_beats();
    if (measure_tmo) begin
      n = 0;
      do begin
        @(negedge aclk);
        n++;
      end while (!m_axis_tvalid && n < 3000);
      check({tag, " tmo_latency"}, 65'(n), 65'(TMO + 1));
    end
    n = 0;
    while (out_q.size() < exp_q.size() && n < 6000) begin
      @(negedge aclk);
      n++;
    end
    repeat (3) @(negedge aclk);
    check({tag, " nbeats"}, 65'(out_q.size()), 65'(exp_q.size()));
    foreach (exp_q[i])
      if (i < out_q.size()) check($sformatf("%s beat%0d", tag, i), out_q[i], exp_q[i]);
    check({tag, " frames_sent"}, 65'(frames_sent), 65'(exp_frames));
    check({tag, " bad_tid_cnt"}, 65'(bad_tid_cnt), 65'(exp_bad));
    check({tag, " idle_valid"}, 65'(m_axis_tvalid), 65'd0);
  endtask

  function automatic void add(input logic [2:0] tid, input logic [63:0] d, input logic last);
    beat_t b;
    b.tid = tid; b.data = d; b.last = last;
    stim.push_back(b);
  endfunction

  initial begin
    int n;
    int ch;
    // Reset state
    #12;
    check("rst tvalid", 65'(m_axis_tvalid), 65'd0);
    check("rst tdata", 65'(m_axis_tdata), 65'd0);
    check("rst tlast", 65'(m_axis_tlast), 65'd0);
    check("rst s_tready", 65'(s_axis_tready), 65'd0);
    check("rst frames", 65'(frames_sent), 65'd0);
    check("rst bad", 65'(bad_tid_cnt), 65'd0);
    @(posedge aclk); #1 areset = 1'b0;

    // 3 W beats closed by tlast
    stim.delete();
    for (int i = 1; i <= 3; i++) add(3'd3, 64'(i), i == 3);
    run_seq("t1", 1'b0);
    check("t1 header", out_q.size() > 0 ? out_q[0] : 65'h0,
          {1'b0, 64'hE7B5_0000_0003_0304 | (CKS ? 64'h80 : 64'h0)});

    // 40 R beats: MAX frame then timeout frame
    stim.delete();
    for (int i = 0; i < 40; i++) add(3'd2, {$urandom, $urandom}, 1'b0);
    run_seq("t2", 1'b1);

    // AR, AR, AW: channel change holds AW
    stim.delete();
    add(3'd0, 64'hA0, 1'b0);
    add(3'd0, 64'hA1, 1'b0);
    add(3'd1, 64'hB0, 1'b1);
    run_seq("t3", 1'b0);

    // 16-beat frame with 1-of-3 output ready
    ready_mode = 1;
    stim.delete();
    for (int i = 0; i < 16; i++) add(3'd3, {$urandom, $urandom}, i == 15);
    run_seq("t4", 1'b0);
    ready_mode = 0;

    // invalid tid between two B beats
    stim.delete();
    add(3'd4, 64'h11, 1'b0);
    add(3'd6, 64'h99, 1'b0);
    add(3'd4, 64'h22, 1'b1);
    run_seq("t5", 1'b0);

    // reset in the middle of payload emission
    ready_mode = 1;
    stim.delete();
    exp_q.delete();
    out_q.delete();
    for (int i = 0; i < 10; i++) add(3'd1, 64'(100 + i), i == 9);
    drive_beats();
    n = 0;
    while (out_q.size() < 3 && n < 500) begin
      @(negedge aclk);
      n++;
    end
    check("t6 in_payload", 65'(out_q.size() >= 3), 65'd1);
    @(posedge aclk); #1 areset = 1'b1;
    #1;
    check("t6 tvalid", 65'(m_axis_tvalid), 65'd0);
    check("t6 tdata", 65'(m_axis_tdata), 65'd0);
    check("t6 tlast", 65'(m_axis_tlast), 65'd0);
    check("t6 frames", 65'(frames_sent), 65'd0);
    check("t6 bad", 65'(bad_tid_cnt), 65'd0);
    @(posedge aclk); #1 areset = 1'b0;
    ready_mode = 0;
    exp_seq = '0;
    exp_frames = '0;
    exp_bad = '0;
    stim.delete();
    for (int i = 0; i < 4; i++) add(3'd0, 64'(200 + i), i == 3);
    run_seq("t6 post", 1'b0);

    // random mixed traffic
    ready_mode = 2;
    for (int r = 0; r < 3; r++) begin
      stim.delete();
      ch = $urandom_range(0, 4);
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 5) == 0) ch = $urandom_range(0, 4);
        add(($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'(ch),
            {$urandom, $urandom}, $urandom_range(0, 7) == 0);
      end
      run_seq($sformatf("rnd%0d", r), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
